// File: rtl/uart_tx_buffered_if.sv
// Write-side bus between the CPU output path and the buffered UART transmitter.
interface uart_tx_buffered_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       overflow;

  modport master (output wr_en, output wr_data, input full, input busy, input overflow);
  modport slave  (input wr_en, input wr_data, output full, output busy, output overflow);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: circular FIFO feeding a start/data/stop
// serialiser. Writes into a full FIFO are dropped and flagged, never stalled.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                clk,
  input  logic                btnc,
  uart_tx_buffered_if.slave   bus,
  output logic                tx
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          push, pop;
  logic [7:0]    head;

  // Serialiser registers and their next values
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;

  // full comes from the registered count, so a pop in the same cycle
  // cannot rescue a write that arrives while full.
  assign bus.full     = (count == FULL_CNT);
  assign bus.busy     = (state_q != IDLE) || (count != '0);
  assign bus.overflow = ovf;
  assign push         = bus.wr_en && !bus.full;
  assign head         = mem[rd_ptr];

  // Byte storage; no reset needed since only count-covered slots are read.
  always_ff @(posedge clk) begin
    if (!btnc && push) mem[wr_ptr] <= bus.wr_data;
  end

  // Pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (btnc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && bus.full) ovf <= 1'b1;
    end
  end

  // Serialiser state register; tx is registered from the next-state decision.
  always_ff @(posedge clk) begin
    if (btnc) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
    end
  end

  // Next-state logic: bit/state advance when the baud counter reads zero;
  // the final stop cycle chains straight into the next start bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_d = head;
          bit_d   = '0;
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (count != '0) begin
            pop     = 1'b1;
            shift_d = head;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4, DEPTH=4).
// Expected line waveforms are built from byte lists with 8N1 framing rules.
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic btnc;
  logic tx;
  uart_tx_buffered_if bus();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clk (clk),
    .btnc(btnc),
    .bus (bus.slave),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle recording of outputs, sampled on the falling edge.
  bit   rec_on = 1'b0;
  logic txs[$];
  logic busys[$];
  logic fulls[$];
  logic ovfs[$];
  always @(negedge clk) begin
    if (rec_on) begin
      txs.push_back(tx);
      busys.push_back(bus.busy);
      fulls.push_back(bus.full);
      ovfs.push_back(bus.overflow);
    end
  end

  logic [7:0] exp_bytes[$];
  logic       exp_tx[$];
  logic [7:0] rxq[$];
  int         ferr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btnc = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    tick();
    tick();
    btnc = 1'b0;
  endtask

  task automatic start_rec();
    txs.delete(); busys.delete(); fulls.delete(); ovfs.delete();
    rec_on = 1'b1;
  endtask

  task automatic run_until(input int n);
    int guard = 0;
    while (txs.size() < n && guard < 5000) begin
      tick();
      guard++;
    end
    rec_on = 1'b0;
  endtask

  // Ideal line: one idle sample, contiguous 8N1 frames, then idle tail.
  task automatic build_exp(input int tail);
    exp_tx.delete();
    exp_tx.push_back(1'b1);
    foreach (exp_bytes[k]) begin
      repeat (CPB) exp_tx.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) exp_tx.push_back(exp_bytes[k][b]);
      repeat (CPB) exp_tx.push_back(1'b1);
    end
    repeat (tail) exp_tx.push_back(1'b1);
  endtask

  function automatic int wave_diff(output int first);
    int d = 0;
    logic a;
    first = -1;
    for (int i = 0; i < exp_tx.size(); i++) begin
      a = (i < txs.size()) ? txs[i] : 1'bx;
      if (a !== exp_tx[i]) begin
        d++;
        if (first < 0) first = i;
      end
    end
    return d;
  endfunction

  function automatic int busy_diff(input int last_busy);
    int d = 0;
    for (int i = 0; i < busys.size(); i++)
      if (busys[i] !== (i <= last_busy)) d++;
    return d;
  endfunction

  // Recover bytes from the recorded line; every bit slot must be steady.
  task automatic decode_rx();
    int i = 0;
    logic lvl;
    logic [7:0] byt;
    rxq.delete();
    ferr = 0;
    while (i + FRAME <= txs.size()) begin
      if (txs[i] === 1'b0) begin
        for (int s = 0; s < 10; s++) begin
          lvl = txs[i + s*CPB];
          for (int c = 1; c < CPB; c++) if (txs[i + s*CPB + c] !== lvl) ferr++;
          if (s >= 1 && s <= 8) byt[s-1] = lvl;
          if (s == 9 && lvl !== 1'b1) ferr++;
        end
        rxq.push_back(byt);
        i += FRAME;
      end else begin
        i++;
      end
    end
    for (int j = i; j < txs.size(); j++) if (txs[j] !== 1'b1) ferr++;
  endtask

  function automatic int rx_diff();
    int d = 0;
    if (rxq.size() != exp_bytes.size()) d++;
    for (int i = 0; i < rxq.size() && i < exp_bytes.size(); i++)
      if (rxq[i] !== exp_bytes[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    int bad;
    do_reset();
    n_checks++;
    if ({tx, bus.busy, bus.full, bus.overflow} !== 4'b1000)
      $display("FAIL reset_state: tx/busy/full/ovf=%b want 1000",
               {tx, bus.busy, bus.full, bus.overflow});
    else n_pass++;

    bus.wr_en = 1'b1; bus.wr_data = 8'($urandom_range(0, 255));
    tick();
    bus.wr_data = 8'($urandom_range(0, 255));
    tick();
    bus.wr_en = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL reset_prebusy: busy=%b want 1", bus.busy);
    else n_pass++;

    btnc = 1'b1;
    tick();
    tick();
    btnc = 1'b0;
    n_checks++;
    if ({tx, bus.busy, bus.full, bus.overflow} !== 4'b1000)
      $display("FAIL reset_midframe: tx/busy/full/ovf=%b want 1000",
               {tx, bus.busy, bus.full, bus.overflow});
    else n_pass++;

    start_rec();
    run_until(3 * FRAME);
    bad = 0;
    foreach (txs[i]) if (txs[i] !== 1'b1 || busys[i] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL reset_quiet: %0d active samples after reset, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_byte();
    int d, f;
    do_reset();
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    start_rec();
    exp_bytes = '{8'h55};
    build_exp(5);
    run_until(exp_tx.size());
    d = wave_diff(f);
    n_checks++;
    if (d != 0) $display("FAIL single_wave: %0d bad samples (first %0d), want 0", d, f);
    else n_pass++;
    d = busy_diff(FRAME);
    n_checks++;
    if (d != 0) $display("FAIL single_busy: %0d bad busy samples, want 0", d);
    else n_pass++;
    decode_rx();
    n_checks++;
    if (rx_diff() != 0 || ferr != 0)
      $display("FAIL single_decode: got %0d bytes first=%h ferr=%0d, want 1 byte 55",
               rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx, ferr);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d, f;
    do_reset();
    bus.wr_en = 1'b1; bus.wr_data = 8'hA3;
    tick();
    start_rec();
    bus.wr_data = 8'h0F;
    tick();
    bus.wr_en = 1'b0;
    exp_bytes = '{8'hA3, 8'h0F};
    build_exp(5);
    run_until(exp_tx.size());
    d = wave_diff(f);
    n_checks++;
    if (d != 0) $display("FAIL b2b_wave: %0d bad samples (first %0d), want 0", d, f);
    else n_pass++;
    d = busy_diff(2 * FRAME);
    n_checks++;
    if (d != 0) $display("FAIL b2b_busy: %0d bad busy samples, want 0", d);
    else n_pass++;
    decode_rx();
    n_checks++;
    if (rx_diff() != 0 || ferr != 0)
      $display("FAIL b2b_decode: got %0d bytes ferr=%0d, want A3 0F", rxq.size(), ferr);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    int d, f;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick();
      if (i == 1) start_rec();
    end
    bus.wr_en = 1'b0;
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_exp(5);
    run_until(exp_tx.size());
    n_checks++;
    if (fulls[3] !== 1'b0 || fulls[4] !== 1'b1)
      $display("FAIL fill_full_rise: full[3]=%b full[4]=%b want 0 1", fulls[3], fulls[4]);
    else n_pass++;
    n_checks++;
    if (ovfs[4] !== 1'b0 || ovfs[5] !== 1'b1)
      $display("FAIL fill_ovf_rise: ovf[4]=%b ovf[5]=%b want 0 1", ovfs[4], ovfs[5]);
    else n_pass++;
    n_checks++;
    if (fulls[FRAME] !== 1'b1 || fulls[FRAME+1] !== 1'b0)
      $display("FAIL fill_full_fall: full[40]=%b full[41]=%b want 1 0",
               fulls[FRAME], fulls[FRAME+1]);
    else n_pass++;
    d = wave_diff(f);
    n_checks++;
    if (d != 0) $display("FAIL fill_wave: %0d bad samples (first %0d), want 0", d, f);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL fill_ovf_sticky: ovf=%b want 1", bus.overflow);
    else n_pass++;
  endtask

  task automatic test_push_pop_full();
    int d, f;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'h10 + 8'(i);
      tick();
      if (i == 0) start_rec();
    end
    bus.wr_en = 1'b0;
    // first frame starts after edge 1, its last stop cycle precedes edge 41
    repeat (FRAME - 4) tick();
    n_checks++;
    if (bus.full !== 1'b1) $display("FAIL ppf_pre_full: full=%b want 1", bus.full);
    else n_pass++;
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b0)
      $display("FAIL ppf_reject: ovf=%b full=%b want 1 0", bus.overflow, bus.full);
    else n_pass++;
    bus.wr_en = 1'b1; bus.wr_data = 8'h15;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.full !== 1'b1) $display("FAIL ppf_refill: full=%b want 1 (count 3->4)", bus.full);
    else n_pass++;
    exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    build_exp(5);
    run_until(exp_tx.size());
    d = wave_diff(f);
    n_checks++;
    if (d != 0) $display("FAIL ppf_wave: %0d bad samples (first %0d), want 0", d, f);
    else n_pass++;
  endtask

  // Writes whenever not full; gap_max>0 inserts random idle cycles.
  task automatic stream(input int gap_max);
    int idx = 0;
    int guard = 0;
    int gap;
    start_rec();
    while (idx < exp_bytes.size() && guard < 20000) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      bus.wr_en = 1'b0;
      repeat (gap) begin tick(); guard++; end
      if (!bus.full) begin
        bus.wr_en = 1'b1; bus.wr_data = exp_bytes[idx];
        idx++;
      end
      tick();
      guard++;
    end
    bus.wr_en = 1'b0;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 20000) begin tick(); guard++; end
    repeat (3) tick();
    rec_on = 1'b0;
    n_checks++;
    if (idx != exp_bytes.size() || bus.busy !== 1'b0)
      $display("FAIL stream_done: wrote %0d of %0d busy=%b want all, 0",
               idx, exp_bytes.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    exp_bytes.delete();
    for (int i = 0; i < 20; i++) exp_bytes.push_back(8'(i));
    do_reset();
    stream(0);
    decode_rx();
    n_checks++;
    if (rx_diff() != 0 || ferr != 0)
      $display("FAIL wrap_decode: got %0d bytes (%0d errs) ferr=%0d want 20 in order",
               rxq.size(), rx_diff(), ferr);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL wrap_ovf: ovf=%b want 0", bus.overflow);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      exp_bytes.delete();
      for (int i = 0; i < 12; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
      do_reset();
      stream(50);
      decode_rx();
      n_checks++;
      if (rx_diff() != 0 || ferr != 0)
        $display("FAIL random_decode: round %0d got %0d bytes (%0d errs) ferr=%0d want 12",
                 r, rxq.size(), rx_diff(), ferr);
      else n_pass++;
      n_checks++;
      if (bus.overflow !== 1'b0 || tx !== 1'b1)
        $display("FAIL random_idle: ovf=%b tx=%b want 0 1", bus.overflow, tx);
      else n_pass++;
    end
  endtask

  initial begin
    btnc = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fill_overflow();
    test_push_pop_full();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Byte-oriented UART transmitter with an internal transmit FIFO; it sits directly downstream of the CPU core's output path and drives the board-level `tx` pin. The CPU pushes bytes with a single-cycle write strobe. The block serialises them as 8N1 frames, back-to-back, without further CPU involvement. Overflow is flagged rather than stalled, so the CPU never blocks on the UART.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `DEPTH`, default 16: FIFO depth in bytes; power of two, ≥ 2.
- `clk` in 1: single system clock; all state updates on rising edge.
- `btnc` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write strobe; one byte accepted per cycle when `full`=0.
- `wr_data` in 8: byte to enqueue, sampled with `wr_en`.
- `full` out 1: FIFO holds `DEPTH` bytes; computed from registered count.
- `busy` out 1: FIFO non-empty or serialiser not IDLE.
- `overflow` out 1: sticky; set when `wr_en`=1 while `full`=1; cleared only by reset.
- `tx` out 1: serial line, registered, idle high.

## Operation
- **FIFO:**
  - Circular buffer with read and write pointers of log2(`DEPTH`) bits, wrapping modulo `DEPTH`.
  - Separate count register of log2(`DEPTH`)+1 bits.
  - Push when `wr_en`=1 and `full`=0.
  - A write while `full`=1 is dropped, sets `overflow`, and leaves the contents unchanged. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- **Serialiser FSM, states IDLE, START, DATA, STOP:**
  - IDLE: `tx`=1. If count≠0, pop the head byte into the shift register, clear the bit counter, load the baud counter with `CLKS_PER_BIT`-1, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After each bit, shift right and increment the 3-bit bit counter. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the final STOP cycle:
    - if count≠0, pop the next byte and go directly to START (no idle gap);
    - otherwise go to IDLE.
- **Baud counter:** ceil(log2(`CLKS_PER_BIT`)) bits; counts down and reloads at 0. The state/bit advance happens on the cycle the counter reads 0.
- **`busy`** = (state≠IDLE) | (count≠0).

## Timing
- **Reset values** (after the first `clk` edge with `btnc`=1): `tx`=1, `full`=0, `busy`=0, `overflow`=0, state=IDLE, count=0, pointers=0.
- **Reset mid-frame:** the frame is aborted, `tx` returns high on the same edge, and queued bytes are discarded.
- **Latency from an empty, idle block:**
  - write sampled at edge k;
  - count=1 after edge k;
  - pop at edge k+1, state=START;
  - `tx` falls after edge k+1 (registered from the START decision), i.e. `tx`=0 first visible in cycle k+1→k+2.
- **Frame timing:**
  - a frame occupies exactly 10×`CLKS_PER_BIT` cycles of `tx`;
  - back-to-back frames are contiguous;
  - the stop bit of frame n is immediately followed by the start bit of frame n+1.
- **`full`:** asserts the cycle after the push that makes count=`DEPTH`. It deasserts the cycle after the pop that frees a slot.
- **Throughput:** one accepted write per cycle into the FIFO. Drain rate is one byte per 10×`CLKS_PER_BIT` cycles.
- **`overflow`:** rises the cycle after the offending write and stays high until reset.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DEPTH`=4.
1. **Reset:** hold `btnc`=1 for 2 cycles mid-frame → next cycle `tx`=1, `busy`=0, `full`=0, `overflow`=0; no further line activity.
2. **Single byte:** write 0x55 → `tx` sequence, 4 cycles each: 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop). Then `busy`=0 one cycle after the stop bit ends. Total low-to-idle time is 40 cycles.
3. **Back-to-back:** write 0xA3 then 0x0F on consecutive cycles → two contiguous frames of 40 cycles each, no idle gap. Decoded bytes are 0xA3 then 0x0F.
4. **Fill and overflow:** write 6 bytes 0x01–0x06 on consecutive cycles →
   - 0x01 is popped one cycle after its write;
   - 0x02–0x05 fill the FIFO, so `full`=1;
   - 0x06 is dropped and `overflow`=1 persists;
   - serial output is exactly 0x01–0x05.
5. **Push/pop same cycle at full:** with the FIFO full, issue a write on the STOP-final cycle → write rejected, `overflow`=1, count goes 4→3.
6. **Pointer wrap:** stream 20 bytes 0x00–0x13, writing whenever `full`=0 → all 20 are received in order; no `overflow`; `busy`=0 at the end.
